uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares the single buart transmitter between NREQ byte-stream requesters, such as the CPU console path and a debug/trace source. Requesters are served round-robin with packet locking: a grant is held until the requester's byte tagged "last" is sent, so packets never interleave. The block drives the buart wr/tx_data strobe interface and paces itself on busy. A lock-timeout frees the transmitter if a granted requester stalls mid-packet.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT, 30000, cycles a locked requester may leave req_valid low mid-packet before its lock is dropped (1 ms at 30 MHz); must be >=1

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester byte available
req_data  in  8*NREQ  byte for requester i in bits [8i+7:8i]
req_last  in  NREQ  byte is final byte of its packet
req_ready  out  NREQ  one-hot accept strobe; a byte transfers when req_valid[i] & req_ready[i]
uart_wr  out  1  one-cycle write strobe to buart
uart_tx_data  out  8  byte to buart, registered, stable while uart_wr is high
uart_busy  in  1  buart busy; high while the transmitter is not idle
grant  out  NREQ  one-hot current owner, 0 when unowned
timeout_pulse  out  1  one-cycle pulse when a lock is dropped by timeout

Behaviour:
- Reset: state=ARB, grant=0, req_ready=0, uart_wr=0, uart_tx_data=8'h00, timeout_pulse=0, priority pointer ptr=0, timeout counter=0. A reset mid-packet drops the lock with no pulse. The buart is reset separately by the same system reset.
- States: ARB, HOLD, SEND, DRAIN.
- ARB: the candidate is the first i with req_valid[i], searching cyclically from ptr. If a candidate exists and uart_busy=0, then:
  - req_ready[cand]=1 combinationally in that cycle;
  - capture data into uart_tx_data and last into last_r;
  - grant<=onehot(cand); next state is SEND.
  - If no candidate exists, or uart_busy=1, stay in ARB with req_ready=0.
- HOLD (locked to grant g): only g is eligible. If req_valid[g] & !uart_busy, then req_ready[g]=1, capture the byte, clear the counter, and go to SEND. Otherwise the counter increments while req_valid[g]=0. When the counter reaches TIMEOUT-1 without a transfer:
  - timeout_pulse=1 for one cycle;
  - grant<=0 and ptr<=g+1 mod NREQ;
  - next state is ARB.
- SEND: uart_wr=1 for exactly one cycle with uart_tx_data held; next state is DRAIN. req_ready=0.
- DRAIN: minimum one cycle, because buart busy rises the cycle after wr and must not be sampled as low in that gap. Afterwards, stay until uart_busy=0. Then:
  - if last_r=1: grant<=0, ptr<=g+1 mod NREQ, next state is ARB;
  - otherwise: next state is HOLD.
- Latency: from accept (ready high) to uart_wr is 1 cycle. Back-to-back bytes are one per buart frame plus 2 cycles.
- req_ready is never asserted in SEND or DRAIN, and never to more than one requester.
- Requesters other than the owner are ignored while locked, regardless of their valid.
- A single-byte packet (last=1 on the first byte) returns to ARB after DRAIN. ptr advance gives fairness.
- Simultaneous events:
  - A timeout cycle coinciding with req_valid[g] rising: the transfer wins, with no pulse.
  - uart_busy high in ARB (e.g. after an external wr) blocks acceptance.
- Width: the counter is $clog2(TIMEOUT+1) bits and saturates; it is not reset outside HOLD. ptr is $clog2(NREQ) bits, and wrap is modulo NREQ (non-power-of-2 NREQ handled explicitly).
- No combinational path from uart_busy to uart_wr.

Decomposition:
- Package uart_arb_pkg holds:
  - the state encoding constants ARB/HOLD/SEND/DRAIN (2 bits);
  - a default TIMEOUT derived from CLKFREQ (30 MHz).
- Sub-module uart_rr_pick (combinational):
  - inputs: NREQ-wide request vector and ptr;
  - outputs: one-hot pick, encoded index, any.
  - It is reusable for future shared peripherals.

Test Plan:
- Single byte: req_valid[0]=1, data=8'h41, last=1, busy model idle → ready[0] for 1 cycle, uart_wr one cycle later with tx_data=8'h41, grant=01 then 00 after busy falls.
- Round-robin: both valid with single-byte packets 8'hA0 / 8'hB0 held continuously → wr sequence A0,B0,A0,B0, never two consecutive bytes from the same requester.
- Packet lock: requester0 sends 3-byte packet 01,02,03(last) while requester1 holds valid with 8'hFF → the uart sees 01,02,03,FF in that order, and ready[1] stays low until the 03 frame drains.
- Timeout: TIMEOUT=16; requester0 sends 8'h11 with last=0 and then drops valid, while requester1 is valid → timeout_pulse after 16 HOLD cycles, the next wr carries requester1 data, and grant=10.
- Busy gap: a bench buart model raises busy one cycle after wr and holds it for 40 cycles → exactly one wr per byte, and no ready while busy=1.
- Reset mid-packet: assert reset during DRAIN of a non-last byte → next cycle grant=0, uart_wr=0, tx_data=00, state ARB, and fresh arbitration starts from requester0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the buart transmit arbiter.
package uart_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    HOLD  = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  // System clock and the default lock timeout of 1 ms at that clock
  localparam int CLKFREQ         = 30_000_000;
  localparam int DEFAULT_TIMEOUT = CLKFREQ / 1000;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the buart strobe interface, bundled for the arbiter.
// master: the arbiter's view. slave: the requesters/buart/observer view.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              uart_wr;
  logic [7:0]        uart_tx_data;
  logic              uart_busy;
  logic [NREQ-1:0]   grant;
  logic              timeout_pulse;

  modport master (
    input  req_valid, req_data, req_last, uart_busy,
    output req_ready, uart_wr, uart_tx_data, grant, timeout_pulse
  );

  modport slave (
    output req_valid, req_data, req_last, uart_busy,
    input  req_ready, uart_wr, uart_tx_data, grant, timeout_pulse
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request searching cyclically upward from i_ptr.
// Purely combinational; reusable for any shared peripheral.
module uart_rr_pick #(
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_pick,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  // One extra bit so ptr+offset can be wrapped explicitly for non-power-of-2 NREQ
  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_slot;

  // Scan offsets 0..NREQ-1 from the pointer and keep the first hit
  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_sum  = '0;
    w_slot = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
      w_slot = w_sum[PW-1:0];
      if (!o_any && i_req[w_slot]) begin
        o_any          = 1'b1;
        o_pick[w_slot] = 1'b1;
        o_idx          = w_slot;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one buart transmitter between NREQ byte-stream requesters.
// Round-robin between packets, locked to the owner until its "last" byte drains.
//
// state | meaning
// ARB   | unowned; accept first valid requester from ptr when buart idle
// HOLD  | locked to grant; wait for owner's next byte, count stall cycles
// SEND  | uart_wr high for one cycle with the captured byte
// DRAIN | wait for buart idle; release on last byte, else back to HOLD
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  uart_tx_arbiter_if.master io_bus
);

  localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_TC   = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

  arb_state_t      r_state;
  logic [NREQ-1:0] r_grant;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_last;
  logic            r_uart_wr;
  logic [7:0]      r_tx_data;
  logic            r_timeout_pulse;

  logic [NREQ-1:0] w_pick;
  logic [PW-1:0]   w_pick_idx;
  logic            w_any;
  logic            w_owner_valid;
  logic            w_accept_arb;
  logic            w_accept_hold;
  logic [NREQ-1:0] w_ready;
  logic [7:0]      w_sel_data;
  logic            w_sel_last;
  logic [PW-1:0]   w_next_ptr;

  uart_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req  (io_bus.req_valid),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx),
    .o_any  (w_any)
  );

  // Accept decisions and the one-hot ready strobe; never in SEND/DRAIN
  always_comb begin
    w_owner_valid = |(io_bus.req_valid & r_grant);
    w_accept_arb  = (r_state == ARB)  && w_any         && !io_bus.uart_busy;
    w_accept_hold = (r_state == HOLD) && w_owner_valid && !io_bus.uart_busy;
    if (w_accept_arb)       w_ready = w_pick;
    else if (w_accept_hold) w_ready = r_grant;
    else                    w_ready = '0;
    w_next_ptr = (r_owner == LAST_IDX) ? '0 : r_owner + PW'(1);
  end

  // Mux the byte and last flag of whichever requester is being accepted
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_ready[i]) begin
        w_sel_data = io_bus.req_data[8*i +: 8];
        w_sel_last = io_bus.req_last[i];
      end
    end
  end

  // Arbiter FSM with registered buart strobe, data, grant and timeout pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= ARB;
      r_grant         <= '0;
      r_owner         <= '0;
      r_ptr           <= '0;
      r_cnt           <= '0;
      r_last          <= 1'b0;
      r_uart_wr       <= 1'b0;
      r_tx_data       <= 8'h00;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_timeout_pulse <= 1'b0;
      case (r_state)
        ARB: begin
          if (w_accept_arb) begin
            r_grant   <= w_pick;
            r_owner   <= w_pick_idx;
            r_tx_data <= w_sel_data;
            r_last    <= w_sel_last;
            r_uart_wr <= 1'b1;
            r_state   <= SEND;
          end
        end
        HOLD: begin
          // A byte arriving in the timeout cycle still transfers
          if (w_accept_hold) begin
            r_tx_data <= w_sel_data;
            r_last    <= w_sel_last;
            r_cnt     <= '0;
            r_uart_wr <= 1'b1;
            r_state   <= SEND;
          end else if (!w_owner_valid) begin
            if (r_cnt >= CNT_TC) begin
              r_timeout_pulse <= 1'b1;
              r_grant         <= '0;
              r_ptr           <= w_next_ptr;
              r_cnt           <= '0;
              r_state         <= ARB;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        SEND: begin
          r_uart_wr <= 1'b0;
          r_state   <= DRAIN;
        end
        DRAIN: begin
          // Entered one cycle after wr, by which time the buart shows busy
          if (!io_bus.uart_busy) begin
            if (r_last) begin
              r_grant <= '0;
              r_ptr   <= w_next_ptr;
              r_state <= ARB;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign io_bus.req_ready     = w_ready;
  assign io_bus.uart_wr       = r_uart_wr;
  assign io_bus.uart_tx_data  = r_tx_data;
  assign io_bus.grant         = r_grant;
  assign io_bus.timeout_pulse = r_timeout_pulse;

endmodule
